// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg
// Shared definitions for the FIFO-draining UART transmitter:
//   tx_state_t      - transmitter FSM state encoding (3 bits)
//   UART_IDLE_LVL   - line level while idle and during the stop bit
//   UART_START_LVL  - line level of the start bit
//   UART_DATA_BITS  - data bits per frame
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } tx_state_t;

    localparam logic        UART_IDLE_LVL  = 1'b1;
    localparam logic        UART_START_LVL = 1'b0;
    localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
// Free-running bit-period counter. bit_end pulses for one cycle every
// CLKS_PER_BIT cycles; restart forces the count back to zero so the next
// bit_end arrives exactly CLKS_PER_BIT cycles after the restart cycle.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   restart  in   realign the bit period
//   bit_end  out  last cycle of the current bit period
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Wrapping at LAST is the per-bit reload.
    always_comb begin
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Pops bytes from a synchronous FIFO (registered data_out) and transmits
// each as an LSB-first 8N1 frame, or 8E1 when PARITY_EN is set.
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   enable      in   permits starting new frames (sampled in IDLE / end of STOP)
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO data_out, valid the cycle after a pop
//   fifo_rd_en  out  one-cycle pop request
//   tx          out  serial line, idles high
//   busy        out  high from the pop until the stop bit completes
//   tx_done     out  one-cycle pulse after the last stop-bit cycle
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

    tx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic [2:0] idx_q, idx_d;
    logic       tx_q, tx_d;
    logic       done_q, done_d;
    logic       bit_end;
    logic       restart;

    // Aligning the timer in LOAD makes START last exactly one bit period.
    assign restart = (state_q == LOAD);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        tx_d    = UART_IDLE_LVL;

        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = fifo_data;
                par_d   = ^fifo_data;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == LAST_IDX) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = (enable && !fifo_empty) ? POP : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level follows the state being entered so tx changes on the
        // same edge as the state.
        case (state_d)
            START:   tx_d = UART_START_LVL;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = UART_IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            idx_q   <= '0;
            tx_q    <= UART_IDLE_LVL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign fifo_rd_en = (state_q == POP);
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT 0: no parity, DUT 1: even parity
    logic       en0 = 1'b0, en1 = 1'b0;
    logic       empty0, empty1;
    logic [7:0] fdata0 = 8'h00, fdata1 = 8'h00;
    logic       rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .enable(en0), .fifo_empty(empty0), .fifo_data(fdata0),
        .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .tx_done(done0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .fifo_empty(empty1), .fifo_data(fdata1),
        .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .tx_done(done1)
    );

    // FIFO models with registered data_out
    logic [7:0]  mem0 [32];
    logic [7:0]  mem1 [32];
    int unsigned wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;

    assign empty0 = (wp0 == rp0);
    assign empty1 = (wp1 == rp1);

    always @(posedge clk) begin
        if (rd0 && (wp0 != rp0)) begin
            fdata0 <= mem0[rp0 % 32];
            rp0    <= rp0 + 1;
        end
    end

    always @(posedge clk) begin
        if (rd1 && (wp1 != rp1)) begin
            fdata1 <= mem1[rp1 % 32];
            rp1    <= rp1 + 1;
        end
    end

    task automatic push0(input logic [7:0] b);
        mem0[wp0 % 32] = b;
        wp0 = wp0 + 1;
    endtask

    task automatic push1(input logic [7:0] b);
        mem1[wp1 % 32] = b;
        wp1 = wp1 + 1;
    endtask

    // Pop monitor for DUT 0
    int   rdcnt0 = 0;
    int   consec0 = 0;
    logic rd0_prev = 1'b0;
    always @(negedge clk) begin
        if (rd0) rdcnt0++;
        if (rd0 && rd0_prev) consec0++;
        rd0_prev = rd0;
    end

    int errors = 0;
    int checks = 0;

    function automatic logic tx_of(input int k);
        return (k == 0) ? tx0 : tx1;
    endfunction

    function automatic logic rd_of(input int k);
        return (k == 0) ? rd0 : rd1;
    endfunction

    // Waits (bounded) for a start bit, then samples nb bits of CPB cycles each.
    // Returns on the last sample of the final bit.
    task automatic frame(input int k, input int nb, output logic [10:0] bits,
                         output int start_c, output int lat, output bit held_ok);
        int   t_rd;
        logic v;
        bits    = '0;
        start_c = -1;
        lat     = -1;
        held_ok = 1'b1;
        t_rd    = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (rd_of(k) && t_rd < 0) t_rd = c;
            if (tx_of(k) == 1'b0) begin
                start_c = c;
                break;
            end
        end
        if (start_c < 0) return;
        if (t_rd >= 0) lat = start_c - t_rd;
        for (int b = 0; b < nb; b++) begin
            for (int s = 0; s < CPB; s++) begin
                if (b != 0 || s != 0) @(negedge clk);
                v = tx_of(k);
                if (s == 0) bits[b] = v;
                else if (v !== bits[b]) held_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx0 !== 1'b1)    begin errors++; $display("FAIL reset_tx0: got %b want 1", tx0); end
        checks++; if (rd0 !== 1'b0)    begin errors++; $display("FAIL reset_rd0: got %b want 0", rd0); end
        checks++; if (busy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy0: got %b want 0", busy0); end
        checks++; if (done0 !== 1'b0)  begin errors++; $display("FAIL reset_done0: got %b want 0", done0); end
        checks++; if (tx1 !== 1'b1)    begin errors++; $display("FAIL reset_tx1: got %b want 1", tx1); end
        checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL reset_busy1: got %b want 0", busy1); end
        rst = 1'b0;
    endtask

    task automatic test_idle_empty;
        en0 = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            checks++; if (rd0 !== 1'b0)   begin errors++; $display("FAIL idle_rd cyc%0d: got %b want 0", c, rd0); end
            checks++; if (tx0 !== 1'b1)   begin errors++; $display("FAIL idle_tx cyc%0d: got %b want 1", c, tx0); end
            checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_busy cyc%0d: got %b want 0", c, busy0); end
        end
        en0 = 1'b0;
    endtask

    task automatic test_single;
        logic [10:0] bits;
        int sc, lat, r0;
        bit ok;
        r0 = rdcnt0;
        push0(8'hA5);
        en0 = 1'b1;
        frame(0, 10, bits, sc, lat, ok);
        checks++; if (sc < 0)   begin errors++; $display("FAIL single_start: got none want start bit"); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", lat); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_hold: got %b want 1", ok); end
        checks++; if (bits[9:0] !== 10'b1_1010_0101_0) begin
            errors++; $display("FAIL single_bits: got %b want %b", bits[9:0], 10'b1_1010_0101_0);
        end
        @(negedge clk);
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", done0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy0); end
        @(negedge clk);
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b want 0", done0); end
        checks++; if (rdcnt0 - r0 !== 1) begin errors++; $display("FAIL single_pops: got %0d want 1", rdcnt0 - r0); end
        en0 = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0]  exp [3];
        logic [10:0] bits;
        int sc, lat, r0;
        bit ok;
        exp[0] = 8'h01; exp[1] = 8'h80; exp[2] = 8'hFF;
        r0 = rdcnt0;
        for (int i = 0; i < 3; i++) push0(exp[i]);
        en0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame(0, 10, bits, sc, lat, ok);
            checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want 2", i, lat); end
            if (i > 0) begin
                checks++; if (sc !== 2) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d want 2", i, sc); end
            end
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_hold[%0d]: got %b want 1", i, ok); end
            checks++; if (bits[9:0] !== {1'b1, exp[i], 1'b0}) begin
                errors++; $display("FAIL b2b_bits[%0d]: got %b want %b", i, bits[9:0], {1'b1, exp[i], 1'b0});
            end
        end
        @(negedge clk);
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", done0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_busy_after: got %b want 0", busy0); end
        checks++; if (rdcnt0 - r0 !== 3) begin errors++; $display("FAIL b2b_pops: got %0d want 3", rdcnt0 - r0); end
        en0 = 1'b0;
    endtask

    task automatic test_parity;
        logic [7:0]  dat [2];
        logic        par [2];
        logic [10:0] bits;
        int sc, lat;
        bit ok;
        dat[0] = 8'h07; par[0] = 1'b1;
        dat[1] = 8'h03; par[1] = 1'b0;
        en1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push1(dat[i]);
            frame(1, 11, bits, sc, lat, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL parity_hold[%0d]: got %b want 1", i, ok); end
            checks++; if (bits[9] !== par[i]) begin
                errors++; $display("FAIL parity_bit[%0d]: got %b want %b", i, bits[9], par[i]);
            end
            checks++; if (bits !== {1'b1, par[i], dat[i], 1'b0}) begin
                errors++; $display("FAIL parity_frame[%0d]: got %b want %b", i, bits, {1'b1, par[i], dat[i], 1'b0});
            end
            @(negedge clk);
            checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL parity_len[%0d]: done got %b want 1", i, done1); end
        end
        en1 = 1'b0;
    endtask

    task automatic test_enable_drop;
        logic [10:0] bits;
        int sc, lat, r0;
        bit ok;
        r0 = rdcnt0;
        push0(8'h3C);
        push0(8'h5A);
        en0 = 1'b1;
        fork
            frame(0, 10, bits, sc, lat, ok);
            begin
                repeat (20) @(negedge clk);
                en0 = 1'b0;
            end
        join
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL endrop_hold: got %b want 1", ok); end
        checks++; if (bits[9:0] !== {1'b1, 8'h3C, 1'b0}) begin
            errors++; $display("FAIL endrop_bits: got %b want %b", bits[9:0], {1'b1, 8'h3C, 1'b0});
        end
        @(negedge clk);
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL endrop_done: got %b want 1", done0); end
        for (int c = 0; c < 30; c++) begin
            checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL endrop_idle_busy cyc%0d: got %b want 0", c, busy0); end
            @(negedge clk);
        end
        checks++; if (rdcnt0 - r0 !== 1) begin errors++; $display("FAIL endrop_no_pop: got %0d want 1", rdcnt0 - r0); end
        en0 = 1'b1;
        @(negedge clk);
        checks++; if (rd0 !== 1'b1) begin errors++; $display("FAIL endrop_pop_after_enable: got %b want 1", rd0); end
        frame(0, 10, bits, sc, lat, ok);
        checks++; if (bits[9:0] !== {1'b1, 8'h5A, 1'b0}) begin
            errors++; $display("FAIL endrop_second_bits: got %b want %b", bits[9:0], {1'b1, 8'h5A, 1'b0});
        end
        @(negedge clk);
        en0 = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [10:0] bits;
        int sc, lat, r0;
        bit ok;
        r0 = rdcnt0;
        push0(8'h96);
        push0(8'h69);
        en0 = 1'b1;
        repeat (27) @(negedge clk);
        checks++; if (tx0 !== 1'b0) begin errors++; $display("FAIL rstmid_bit5_pre: got %b want 0", tx0); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx0 !== 1'b1)   begin errors++; $display("FAIL rstmid_tx: got %b want 1", tx0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
        checks++; if (rd0 !== 1'b0)   begin errors++; $display("FAIL rstmid_rd: got %b want 0", rd0); end
        rst = 1'b0;
        frame(0, 10, bits, sc, lat, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_hold: got %b want 1", ok); end
        checks++; if (bits[9:0] !== {1'b1, 8'h69, 1'b0}) begin
            errors++; $display("FAIL rstmid_bits: got %b want %b", bits[9:0], {1'b1, 8'h69, 1'b0});
        end
        @(negedge clk);
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL rstmid_done: got %b want 1", done0); end
        checks++; if (rdcnt0 - r0 !== 2) begin errors++; $display("FAIL rstmid_pops: got %0d want 2", rdcnt0 - r0); end
        en0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_empty();
        test_single();
        test_back_to_back();
        test_parity();
        test_enable_drop();
        test_reset_mid();
        checks++; if (consec0 !== 0) begin errors++; $display("FAIL rd_consecutive: got %0d want 0", consec0); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
